// File: rtl/mmu_page_mapper.sv
// Purpose : programmable page mapper; ADDR page -> chip select, bank, write protect.
// Latency : decode is combinational; register writes take effect on the next cycle.
// Backpr. : none; every register write and every CPU bus cycle is accepted.
//
// Ports:
//   CLK, RESET        clock and synchronous active-high reset
//   ADDR, ADDR_VALID  CPU page index and bus-cycle qualifier
//   CPU_RW_N          1 = CPU read, 0 = CPU write
//   REG_*             register window: MAP[0..NP-1], CTRL at index NP
//   CE_N              active-low selects {ACIA, VIA, RAM, EEPROM}
//   BANK              physical bank of the effective entry for ADDR
//   WP_FAULT          sticky write-protect fault (CTRL bit1)
module mmu_page_mapper #(
    parameter int PAGE_BITS = 3,
    parameter int BANK_BITS = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [PAGE_BITS-1:0] ADDR,
    input  logic                 ADDR_VALID,
    input  logic                 CPU_RW_N,
    input  logic                 REG_SEL,
    input  logic                 REG_WE,
    input  logic [PAGE_BITS:0]   REG_ADDR,
    input  logic [7:0]           REG_WDATA,
    output logic [7:0]           REG_RDATA,
    output logic [3:0]           CE_N,
    output logic [BANK_BITS-1:0] BANK,
    output logic                 WP_FAULT
);

    localparam int NP = 1 << PAGE_BITS;
    localparam logic [PAGE_BITS:0] CTRL_IDX = (PAGE_BITS+1)'(NP);

    localparam logic [1:0] DEV_EEPROM = 2'd0;
    localparam logic [1:0] DEV_RAM    = 2'd1;
    localparam logic [1:0] DEV_VIA    = 2'd2;

    typedef struct packed {
        logic                 wp;
        logic [1:0]           dev;
        logic [BANK_BITS-1:0] bank;
    } entry_t;

    entry_t map_q [NP];
    logic   en_q;
    logic   fault_q;
    logic   lock_q;

    entry_t eff;
    entry_t rd_entry;
    logic   wp_block;
    logic   map_wr;
    logic   ctrl_wr;

    // Power-on map: top page boots from EEPROM (write protected), the page
    // below it holds the VIA, everything else is identity-mapped RAM.
    // The same table is the live decode whenever EN=0.
    function automatic entry_t reset_entry(input int idx);
        entry_t e;
        if (idx == NP - 1) begin
            e.wp   = 1'b1;
            e.dev  = DEV_EEPROM;
            e.bank = '0;
        end else if (idx == NP - 2) begin
            e.wp   = 1'b0;
            e.dev  = DEV_VIA;
            e.bank = '0;
        end else begin
            e.wp   = 1'b0;
            e.dev  = DEV_RAM;
            e.bank = BANK_BITS'(idx);
        end
        return e;
    endfunction

    assign eff      = en_q ? map_q[ADDR] : reset_entry(int'(ADDR));
    assign wp_block = ADDR_VALID && !CPU_RW_N && eff.wp;

    // A blocked write drops every select so the protected device never sees it.
    always_comb begin
        CE_N = 4'b1111;
        if (ADDR_VALID && !wp_block) begin
            CE_N[eff.dev] = 1'b0;
        end
    end

    assign BANK     = eff.bank;
    assign WP_FAULT = fault_q;

    assign map_wr  = REG_SEL && REG_WE && !REG_ADDR[PAGE_BITS] && !lock_q;
    assign ctrl_wr = REG_SEL && REG_WE && (REG_ADDR == CTRL_IDX);

    assign rd_entry = map_q[REG_ADDR[PAGE_BITS-1:0]];

    always_comb begin
        REG_RDATA = 8'h00;
        if (!REG_ADDR[PAGE_BITS]) begin
            REG_RDATA = {rd_entry.wp, rd_entry.dev, 5'(rd_entry.bank)};
        end else if (REG_ADDR == CTRL_IDX) begin
            REG_RDATA = {5'b0, lock_q, fault_q, en_q};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NP; i++) begin
                map_q[i] <= reset_entry(i);
            end
            en_q    <= 1'b0;
            fault_q <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            if (map_wr) begin
                map_q[REG_ADDR[PAGE_BITS-1:0]] <= {REG_WDATA[7], REG_WDATA[6:5],
                                                   REG_WDATA[BANK_BITS-1:0]};
            end
            if (ctrl_wr) begin
                en_q <= REG_WDATA[0];
                if (REG_WDATA[2]) begin
                    lock_q <= 1'b1;
                end
            end
            // A new fault on the same edge as a clear must not be lost.
            if (wp_block) begin
                fault_q <= 1'b1;
            end else if (ctrl_wr && REG_WDATA[1]) begin
                fault_q <= 1'b0;
            end
        end
    end

    // Bank-field bits above BANK_BITS are not stored.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, REG_WDATA[4:0]};

endmodule

// File: tb/tb_mmu_page_mapper.sv
module tb_mmu_page_mapper;

    localparam int NP = 8;
    localparam int BB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] addr;
    logic       av;
    logic       rw_n;
    logic       sel;
    logic       we;
    logic [3:0] ra;
    logic [7:0] wd;
    logic [7:0] rdata;
    logic [3:0] ce_n;
    logic [3:0] bank;
    logic       wp_fault;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mmu_page_mapper #(.PAGE_BITS(3), .BANK_BITS(4)) dut (
        .CLK       (clk),
        .RESET     (rst),
        .ADDR      (addr),
        .ADDR_VALID(av),
        .CPU_RW_N  (rw_n),
        .REG_SEL   (sel),
        .REG_WE    (we),
        .REG_ADDR  (ra),
        .REG_WDATA (wd),
        .REG_RDATA (rdata),
        .CE_N      (ce_n),
        .BANK      (bank),
        .WP_FAULT  (wp_fault)
    );

    // Reference model: the register file as the CPU sees it (readback bytes).
    logic [7:0] m_map [NP];
    bit m_en, m_fault, m_lock;

    function automatic logic [7:0] dflt(input int i);
        if (i == NP - 1) return 8'h80;
        if (i == NP - 2) return 8'h40;
        return 8'h20 | 8'(i % (1 << BB));
    endfunction

    function automatic logic [7:0] eff_byte(input int a);
        return m_en ? m_map[a] : dflt(a);
    endfunction

    function automatic logic [3:0] exp_ce(input logic v, input logic r, input int a);
        logic [7:0] e;
        e = eff_byte(a);
        if (!v) return 4'hF;
        if (!r && e[7]) return 4'hF;
        return 4'hF & ~(4'b0001 << e[6:5]);
    endfunction

    function automatic logic [7:0] exp_rd(input int r);
        if (r < NP) return m_map[r];
        if (r == NP) return {5'b0, m_lock, m_fault, m_en};
        return 8'h00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) m_map[i] = dflt(i);
        m_en = 0; m_fault = 0; m_lock = 0;
    endtask

    // Applies the effect of the coming rising edge using the current inputs.
    task automatic model_edge();
        bit fault_evt;
        if (rst) begin
            model_reset();
            return;
        end
        fault_evt = av && !rw_n && eff_byte(int'(addr))[7];
        if (sel && we) begin
            if (int'(ra) < NP && !m_lock) begin
                m_map[ra] = wd & (8'hE0 | 8'((1 << BB) - 1));
            end else if (int'(ra) == NP) begin
                m_en = wd[0];
                if (wd[1]) m_fault = 0;
                if (wd[2]) m_lock = 1;
            end
        end
        if (fault_evt) m_fault = 1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       av;
        logic       rw_n;
        logic [2:0] addr;
        logic       sel;
        logic       we;
        logic [3:0] ra;
        logic [7:0] wd;
        logic [3:0] ce;
        logic [3:0] bank;
        logic [7:0] rd;
        logic       flt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic r, input logic a_v, input logic rw,
                               input logic [2:0] a, input logic s, input logic w,
                               input logic [3:0] rad, input logic [7:0] d,
                               input logic [3:0] c, input logic [3:0] b,
                               input logic [7:0] rdv, input logic f);
        vec_t x;
        x.rst = r; x.av = a_v; x.rw_n = rw; x.addr = a; x.sel = s; x.we = w;
        x.ra = rad; x.wd = d; x.ce = c; x.bank = b; x.rd = rdv; x.flt = f;
        return x;
    endfunction

    task automatic drive(input vec_t x);
        rst = x.rst; av = x.av; rw_n = x.rw_n; addr = x.addr;
        sel = x.sel; we = x.we; ra = x.ra; wd = x.wd;
    endtask

    // Outputs are compared before the edge, i.e. against pre-edge state.
    task automatic run_vec(input string tag, input vec_t x);
        drive(x);
        @(negedge clk);
        check($sformatf("%s ce_n", tag), 8'(ce_n), 8'(x.ce));
        check($sformatf("%s bank", tag), 8'(bank), 8'(x.bank));
        check($sformatf("%s rdata", tag), rdata, x.rd);
        check($sformatf("%s wp_fault", tag), 8'(wp_fault), 8'(x.flt));
        model_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst av rw addr sel we ra wd | ce bank rd flt
        for (int a = 0; a < 6; a++)
            tbl.push_back(v(0,1,1,3'(a),0,0,4'(a),8'h00, 4'hD,4'(a),8'h20+8'(a),0));
        tbl.push_back(v(0,1,1,6,0,0,6,8'h00, 4'hB,0,8'h40,0));
        tbl.push_back(v(0,1,1,7,0,0,7,8'h00, 4'hE,0,8'h80,0));
        tbl.push_back(v(0,0,1,3,0,0,8,8'h00, 4'hF,3,8'h00,0));
        tbl.push_back(v(0,0,1,2,1,1,2,8'h63, 4'hF,2,8'h22,0));
        tbl.push_back(v(0,1,1,2,0,0,2,8'h00, 4'hD,2,8'h63,0));
        tbl.push_back(v(0,1,1,2,1,1,8,8'h01, 4'hD,2,8'h00,0));
        tbl.push_back(v(0,1,1,2,0,0,8,8'h00, 4'h7,3,8'h01,0));
        tbl.push_back(v(0,1,1,2,1,1,8,8'h00, 4'h7,3,8'h01,0));
        tbl.push_back(v(0,1,1,2,0,0,8,8'h00, 4'hD,2,8'h00,0));
        tbl.push_back(v(0,1,0,7,0,0,8,8'h00, 4'hF,0,8'h00,0));
        tbl.push_back(v(0,1,1,7,0,0,8,8'h00, 4'hE,0,8'h02,1));
        tbl.push_back(v(0,0,1,7,0,0,8,8'h00, 4'hF,0,8'h02,1));
        tbl.push_back(v(0,0,1,0,1,1,8,8'h02, 4'hF,0,8'h02,1));
        tbl.push_back(v(0,0,1,0,0,0,8,8'h00, 4'hF,0,8'h00,0));
        tbl.push_back(v(0,0,1,0,1,1,8,8'h05, 4'hF,0,8'h00,0));
        tbl.push_back(v(0,1,1,0,1,1,0,8'h40, 4'hD,0,8'h20,0));
        tbl.push_back(v(0,1,1,0,0,0,0,8'h00, 4'hD,0,8'h20,0));
        tbl.push_back(v(0,0,1,0,1,1,8,8'h00, 4'hF,0,8'h05,0));
        tbl.push_back(v(0,0,1,0,0,0,8,8'h00, 4'hF,0,8'h04,0));
        tbl.push_back(v(0,1,0,7,0,0,8,8'h00, 4'hF,0,8'h04,0));
        tbl.push_back(v(0,1,0,7,1,1,8,8'h02, 4'hF,0,8'h06,1));
        tbl.push_back(v(0,0,1,7,0,0,8,8'h00, 4'hF,0,8'h06,1));
        tbl.push_back(v(0,0,1,7,1,1,8,8'h02, 4'hF,0,8'h06,1));
        tbl.push_back(v(0,0,1,7,0,0,8,8'h00, 4'hF,0,8'h04,0));
        tbl.push_back(v(1,0,1,1,1,1,8,8'h01, 4'hF,1,8'h04,0));
        tbl.push_back(v(0,0,1,1,0,0,8,8'h00, 4'hF,1,8'h00,0));
        tbl.push_back(v(0,0,1,1,1,1,1,8'hFF, 4'hF,1,8'h21,0));
        tbl.push_back(v(0,0,1,1,0,0,1,8'h00, 4'hF,1,8'hEF,0));
        tbl.push_back(v(0,0,1,1,1,1,9,8'hFF, 4'hF,1,8'h00,0));
        tbl.push_back(v(0,0,1,1,0,0,9,8'h00, 4'hF,1,8'h00,0));
        tbl.push_back(v(0,0,1,1,0,0,15,8'h00, 4'hF,1,8'h00,0));
        tbl.push_back(v(0,0,1,1,0,0,8,8'h00, 4'hF,1,8'h00,0));

        rst = 1; av = 0; rw_n = 1; addr = 0; sel = 0; we = 0; ra = 0; wd = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i]);

        // Randomized traffic against the reference model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst  = ($urandom_range(0, 49) == 0);
            av   = 1'($urandom);
            rw_n = 1'($urandom);
            addr = 3'($urandom);
            sel  = ($urandom_range(0, 2) == 0);
            we   = 1'($urandom);
            ra   = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom);
            wd   = 8'($urandom);
            @(negedge clk);
            check($sformatf("rand%0d ce_n", cyc), 8'(ce_n), 8'(exp_ce(av, rw_n, int'(addr))));
            check($sformatf("rand%0d bank", cyc), 8'(bank), 8'(eff_byte(int'(addr))) & 8'h0F);
            check($sformatf("rand%0d rdata", cyc), rdata, exp_rd(int'(ra)));
            check($sformatf("rand%0d wp_fault", cyc), 8'(wp_fault), 8'(m_fault));
            model_edge();
            @(posedge clk);
            #1;
        end

        // Decode in the same cycle as a MAP write to that page sees the old entry.
        run_vec("hs_rst",  v(1,0,1,3,0,0,8,8'h00, exp_ce(0,1,3),
                             4'(eff_byte(3)), exp_rd(8), m_fault));
        run_vec("hs_en",   v(0,0,1,3,1,1,8,8'h01, 4'hF,3,8'h00,0));
        run_vec("hs_wr",   v(0,1,1,3,1,1,3,8'h61, 4'hD,3,8'h23,0));
        run_vec("hs_new",  v(0,1,1,3,0,0,3,8'h00, 4'h7,1,8'h61,0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mmu_page_mapper.md
Name: mmu_page_mapper

Overview:
- Programmable successor to the fixed three-bit address decoder in the CPLD MMU.
- Splits the CPU address space into 2^PAGE_BITS pages. Each page has a map register that selects:
  - the target device chip-select: EEPROM, RAM, VIA or ACIA;
  - a physical bank number;
  - a write-protect bit.
- The CPU programs the map through a small register window.
- Chip-select decode is combinational from the registered map. Adds a map-enable bit, a lock bit and a sticky write-protect fault flag.

Parameters:
- PAGE_BITS, 3: number of upper CPU address bits decoded; page count = 2^PAGE_BITS; legal range 2..4.
- BANK_BITS, 4: width of the physical bank output; legal range 1..5.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- ADDR  input  PAGE_BITS  CPU address bits [15:16-PAGE_BITS]; the page index.
- ADDR_VALID  input  1  CPU bus cycle active; when 0, all CE_N are high.
- CPU_RW_N  input  1  1 = read cycle, 0 = write cycle.
- REG_SEL  input  1  MMU register window selected.
- REG_WE  input  1  register write strobe; a write commits on the edge where REG_SEL=1 and REG_WE=1.
- REG_ADDR  input  PAGE_BITS+1  register index.
- REG_WDATA  input  8  register write data.
- REG_RDATA  output  8  combinational readback of the register at REG_ADDR.
- CE_N  output  4  active-low chip selects: bit0 EEPROM, bit1 RAM, bit2 VIA, bit3 ACIA.
- BANK  output  BANK_BITS  physical bank of the current page.
- WP_FAULT  output  1  sticky write-protect fault flag; same bit as CTRL bit1.

Behaviour:
- Register map:
  - Index 0..2^PAGE_BITS-1 are the map entries MAP[i].
  - Index 2^PAGE_BITS is CTRL.
  - Indices above CTRL read 0x00 and ignore writes.
- MAP entry layout:
  - bit7 WP;
  - bits6:5 DEV (0 EEPROM, 1 RAM, 2 VIA, 3 ACIA);
  - bits4:0 bank field, of which only the low BANK_BITS are stored; unused bits read 0.
- CTRL layout:
  - bit0 EN;
  - bit1 FAULT: read returns the sticky flag; writing 1 clears it, writing 0 leaves it unchanged;
  - bit2 LOCK: a set-only bit, cleared only by reset;
  - bits7:3 read 0.
- Reset values (NP = 2^PAGE_BITS):
  - MAP[NP-1] = EEPROM, bank 0, WP=1.
  - MAP[NP-2] = VIA, bank 0, WP=0.
  - All other MAP[i] = RAM, bank = i mod 2^BANK_BITS, WP=0.
  - CTRL: EN=0, FAULT=0, LOCK=0.
  - REG_RDATA follows REG_ADDR; CE_N=4'b1111 while ADDR_VALID=0.
- Effective entry:
  - EN=1: MAP[ADDR].
  - EN=0: the reset-default entry for ADDR, regardless of MAP contents.
  - MAP registers keep their contents while EN=0.
- Decode (combinational, zero latency):
  - If ADDR_VALID=1, assert CE_N[DEV]=0 for the effective entry; exactly one CE_N is low.
  - BANK = effective bank at all times, independent of ADDR_VALID.
- Write protect:
  - Condition: ADDR_VALID=1, CPU_RW_N=0 and effective WP=1.
  - While the condition holds, all CE_N are forced high combinationally.
  - FAULT is set on that edge.
  - Reads of a WP page are unaffected.
- Register writes:
  - Commit at the edge and take effect on the decode from the next cycle.
  - While LOCK=1, MAP writes are ignored. CTRL writes still update EN and clear FAULT; LOCK stays set.
- Simultaneous events:
  - FAULT set event and a write-1-to-clear on the same edge: set wins, FAULT=1.
  - A CPU decode in the same cycle as a MAP write to that page uses the old entry.
  - A CTRL write setting LOCK and any MAP write cannot share an edge; there is one REG_ADDR per cycle.
- Reset mid-operation: on the reset edge, all registers return to reset values regardless of REG_WE or fault activity.

Test Plan:
- Reset, PAGE_BITS=3, EN=0, ADDR_VALID=1:
  - ADDR sweep 0..7 -> CE_N = 1101 for pages 0..5, 1011 for page 6, 1110 for page 7;
  - BANK = 0..5, then 0, 0.
- Write MAP[2]=0x63 (ACIA, bank 3), then CTRL=0x01:
  - next cycle ADDR=2 -> CE_N=0111, BANK=3;
  - write CTRL=0x00 -> ADDR=2 gives CE_N=1101, BANK=2 again.
- Default map, CPU write to page 7 (CPU_RW_N=0) -> CE_N=1111 that cycle, WP_FAULT=1 next edge and stays 1;
  - CPU read of page 7 -> CE_N=1110;
  - write CTRL=0x02 -> FAULT clears.
- Write CTRL=0x05 (EN+LOCK), then MAP[0]=0x40 -> REG_RDATA for MAP[0] stays 0x20, ADDR=0 CE_N=1101;
  - write CTRL=0x00 -> EN=0, LOCK still 1 (readback 0x04).
- Fault event on the same edge as a CTRL=0x02 write -> WP_FAULT=1 afterwards.
- Program MAP[1]=0xFF with BANK_BITS=4 -> readback 0xEF.
- Assert RESET mid-sequence with REG_WE=1 -> all registers return to reset defaults and the write is discarded.
